// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the core fetch path.
// Word store with side write port, fixed-latency valid/ready response.
module imem_fetch_responder #(
    parameter int                ADDR_W  = 64,
    parameter int                DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = 64'h80000000,
    parameter int                LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_data
);

    localparam int   IDX_W  = $clog2(DEPTH);
    localparam int   CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  addr_sel;
    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  widx;
    logic [IDX_W-1:0]   idx_sel;
    logic               err_sel;

    // Decode the address that is about to be read: the live request when
    // reading on the accept edge, otherwise the latched one.
    always_comb begin
        addr_sel = (state == WAIT) ? addr_q : req_addr;
        off      = addr_sel - BASE;
        widx     = off >> 2;
        idx_sel  = widx[IDX_W-1:0];
        err_sel  = (addr_sel[1:0] != 2'b00)
                 | (addr_sel < BASE)
                 | (widx >= ADDR_W'(DEPTH));
    end

    // A new request may be taken from IDLE, or from RESP as the response drains.
    always_comb begin
        req_ready = rst && !flush
                 && ((state == IDLE) || ((state == RESP) && resp_ready));
    end

    // Loader port; reads in the FSM see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // Fetch FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_inst  <= 32'h0;
            resp_err   <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (state == RESP && !resp_ready) begin
                        state <= RESP;
                    end else if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= CNT_W'(LATENCY - 1);
                        if (DIRECT) begin
                            resp_err   <= err_sel;
                            resp_inst  <= err_sel ? 32'h0 : mem[idx_sel];
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_valid <= 1'b0;
                            state      <= WAIT;
                        end
                    end else begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_err   <= err_sel;
                        resp_inst  <= err_sel ? 32'h0 : mem[idx_sel];
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder.
// Hand-computed expectations, LATENCY=2, DEPTH=4096.
module tb_imem_fetch_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        flush;
    logic        wr_en;
    logic [11:0] wr_idx;
    logic [31:0] wr_data;

    int n_cmp;
    int n_bad;

    imem_fetch_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_inst (resp_inst),
        .resp_err  (resp_err),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] i, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_idx  = i;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [63:0] a,
                         input logic [31:0] ei, input logic ee);
        req_addr   = a;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        #1;
        chk({tag, ".rdy"}, 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk({tag, ".v0"}, 64'(resp_valid), 64'd0);
        step();
        chk({tag, ".v1"}, 64'(resp_valid), 64'd0);
        step();
        chk({tag, ".v2"}, 64'(resp_valid), 64'd1);
        chk({tag, ".inst"}, 64'(resp_inst), 64'(ei));
        chk({tag, ".err"}, 64'(resp_err), 64'(ee));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, ".done"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_data    = '0;

        step();
        step();
        chk("rst.valid", 64'(resp_valid), 64'd0);
        chk("rst.inst", 64'(resp_inst), 64'd0);
        chk("rst.err", 64'(resp_err), 64'd0);
        chk("rst.rdy", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rel.rdy", 64'(req_ready), 64'd1);

        // T1: basic fetches
        wr(12'd0, 32'h00100093);
        wr(12'd1, 32'h00000513);
        wr(12'd3, 32'h00000013);
        fetch("t1a", 64'h80000000, 32'h00100093, 1'b0);
        fetch("t1b", 64'h80000004, 32'h00000513, 1'b0);

        // T2: faults
        fetch("t2mis", 64'h80000002, 32'h0, 1'b1);
        fetch("t2hi", 64'h80004000, 32'h0, 1'b1);
        fetch("t2lo", 64'h7FFFFFFC, 32'h0, 1'b1);

        // T3: backpressure then back-to-back accept
        req_addr  = 64'h80000004;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3.hold.v", 64'(resp_valid), 64'd1);
            chk("t3.hold.i", 64'(resp_inst), 64'h00000513);
            chk("t3.hold.r", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 64'h80000000;
        #1;
        chk("t3.b2b.rdy", 64'(req_ready), 64'd1);
        step();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("t3.b2b.v0", 64'(resp_valid), 64'd0);
        step();
        chk("t3.b2b.v1", 64'(resp_valid), 64'd0);
        step();
        chk("t3.b2b.v2", 64'(resp_valid), 64'd1);
        chk("t3.b2b.i", 64'(resp_inst), 64'h00100093);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // T4: flush in WAIT
        req_addr  = 64'h80000004;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4.wait.v", 64'(resp_valid), 64'd0);
            step();
        end
        chk("t4.wait.rdy", 64'(req_ready), 64'd1);
        fetch("t4.after", 64'h80000004, 32'h00000513, 1'b0);

        // T4: flush in RESP with resp_ready
        req_addr  = 64'h80000000;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("t4.resp.v", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        flush      = 1'b1;
        #1;
        chk("t4.resp.rdy", 64'(req_ready), 64'd0);
        step();
        flush      = 1'b0;
        resp_ready = 1'b0;
        chk("t4.resp.drop", 64'(resp_valid), 64'd0);
        step();
        chk("t4.resp.drop2", 64'(resp_valid), 64'd0);

        // T4: flush in IDLE blocks acceptance
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h80000000;
        #1;
        chk("t4.idle.rdy", 64'(req_ready), 64'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        step();
        step();
        chk("t4.idle.v", 64'(resp_valid), 64'd0);

        // T5: write on the read edge returns old word
        req_addr  = 64'h8000000C;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        wr_en   = 1'b1;
        wr_idx  = 12'd3;
        wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        chk("t5.old.v", 64'(resp_valid), 64'd1);
        chk("t5.old.i", 64'(resp_inst), 64'h00000013);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        fetch("t5.new", 64'h8000000C, 32'hDEADBEEF, 1'b0);

        // T6: reset while in WAIT
        req_addr  = 64'h80000004;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("t6.rst.v", 64'(resp_valid), 64'd0);
        chk("t6.rst.rdy", 64'(req_ready), 64'd0);
        step();
        chk("t6.rst.v2", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("t6.rel.rdy", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t6.none", 64'(resp_valid), 64'd0);
            step();
        end
        fetch("t6.w0", 64'h80000000, 32'h00100093, 1'b0);
        fetch("t6.w3", 64'h8000000C, 32'hDEADBEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
